// File: rtl/tank_ctrl.sv
// Two-player tank game key controller.
// Turns PS2 key make/release events into per-player direction, fire and game state.
module tank_ctrl #(
  parameter int unsigned FIRE_COOLDOWN = 25000000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic [7:0] ascii,
  input  logic       press,
  output logic [2:0] p1_dir,
  output logic       p1_fire,
  output logic [2:0] p2_dir,
  output logic       p2_fire,
  output logic [1:0] game_state,
  output logic       start
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(FIRE_COOLDOWN);
  localparam logic [CNT_W-1:0] CD_ONE  = CNT_W'(1);

  localparam logic [7:0] K_ENTER = 8'h0D;
  localparam logic [7:0] K_BKSP  = 8'h08;
  localparam logic [7:0] K_PAUSE = 8'h70;
  localparam logic [7:0] K_W     = 8'h77;
  localparam logic [7:0] K_S     = 8'h73;
  localparam logic [7:0] K_A     = 8'h61;
  localparam logic [7:0] K_D     = 8'h64;
  localparam logic [7:0] K_SPACE = 8'h20;
  localparam logic [7:0] K_I     = 8'h69;
  localparam logic [7:0] K_K     = 8'h6B;
  localparam logic [7:0] K_J     = 8'h6A;
  localparam logic [7:0] K_L     = 8'h6C;
  localparam logic [7:0] K_ZERO  = 8'h30;

  state_t           state;
  logic             prev_press;
  logic [7:0]       prev_ascii;
  logic [CNT_W-1:0] cd1;
  logic [CNT_W-1:0] cd2;
  logic             make_ev;
  logic             rel_ev;
  logic [2:0]       p1_key;
  logic [2:0]       p2_key;

  assign game_state = state;

  // Held keys repeat identical codes; only a change counts as a new make.
  assign make_ev = press && (ascii != 8'h00) &&
                   ((press != prev_press) || (ascii != prev_ascii));
  assign rel_ev  = !press && prev_press;

  always_comb begin
    p1_key = 3'd0;
    p2_key = 3'd0;
    unique case (1'b1)
      (ascii == K_W): p1_key = 3'd1;
      (ascii == K_S): p1_key = 3'd2;
      (ascii == K_A): p1_key = 3'd3;
      (ascii == K_D): p1_key = 3'd4;
      (ascii == K_I): p2_key = 3'd1;
      (ascii == K_K): p2_key = 3'd2;
      (ascii == K_J): p2_key = 3'd3;
      (ascii == K_L): p2_key = 3'd4;
      default: ;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_press <= 1'b0;
      prev_ascii <= 8'h00;
      cd1        <= '0;
      cd2        <= '0;
      p1_dir     <= 3'd0;
      p2_dir     <= 3'd0;
      p1_fire    <= 1'b0;
      p2_fire    <= 1'b0;
      start      <= 1'b0;
    end else begin
      prev_press <= press;
      prev_ascii <= ascii;
      p1_fire    <= 1'b0;
      p2_fire    <= 1'b0;
      start      <= 1'b0;
      if (cd1 != '0) cd1 <= cd1 - CD_ONE;
      if (cd2 != '0) cd2 <= cd2 - CD_ONE;
      if (make_ev) begin
        unique case (state)
          IDLE: begin
            if (ascii == K_ENTER) begin
              state <= RUN;
              start <= 1'b1;
            end
          end
          RUN: begin
            if (ascii == K_PAUSE) begin
              state  <= PAUSE;
              p1_dir <= 3'd0;
              p2_dir <= 3'd0;
            end else if (ascii == K_BKSP) begin
              state  <= IDLE;
              p1_dir <= 3'd0;
              p2_dir <= 3'd0;
              cd1    <= '0;
              cd2    <= '0;
            end else begin
              if (p1_key != 3'd0) p1_dir <= p1_key;
              if (p2_key != 3'd0) p2_dir <= p2_key;
              if ((ascii == K_SPACE) && (cd1 == '0)) begin
                p1_fire <= 1'b1;
                cd1     <= CD_LOAD;
              end
              if ((ascii == K_ZERO) && (cd2 == '0)) begin
                p2_fire <= 1'b1;
                cd2     <= CD_LOAD;
              end
            end
          end
          PAUSE: begin
            if (ascii == K_PAUSE) begin
              state <= RUN;
            end else if (ascii == K_BKSP) begin
              state <= IDLE;
              cd1   <= '0;
              cd2   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (rel_ev) begin
        p1_dir <= 3'd0;
        p2_dir <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_tank_ctrl.sv
// Bench for tank_ctrl: directed scenarios plus random key traffic
// checked against an event-level reference model.
module tb_tank_ctrl;

  localparam int FC = 10;

  logic       clk_100mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       press = 1'b0;
  logic [2:0] p1_dir;
  logic       p1_fire;
  logic [2:0] p2_dir;
  logic       p2_fire;
  logic [1:0] game_state;
  logic       start;

  tank_ctrl #(.FIRE_COOLDOWN(FC), .CNT_W(4)) dut (
    .clk_100mhz(clk_100mhz),
    .rst_n(rst_n),
    .ascii(ascii),
    .press(press),
    .p1_dir(p1_dir),
    .p1_fire(p1_fire),
    .p2_dir(p2_dir),
    .p2_fire(p2_fire),
    .game_state(game_state),
    .start(start)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int checks = 0;
  int errors = 0;

  // Reference model: event view of the game.
  int m_state, m_p1d, m_p2d, m_f1, m_f2, m_start;
  int m_prev_p, m_prev_a;
  int cyc, last1, last2;
  int p1_pulses, p2_pulses;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string w);
    chk({w, ".p1_dir"}, 32'(p1_dir), m_p1d);
    chk({w, ".p2_dir"}, 32'(p2_dir), m_p2d);
    chk({w, ".p1_fire"}, 32'(p1_fire), m_f1);
    chk({w, ".p2_fire"}, 32'(p2_fire), m_f2);
    chk({w, ".state"}, 32'(game_state), m_state);
    chk({w, ".start"}, 32'(start), m_start);
  endtask

  function automatic int dir_of(input int a, input int player);
    int d;
    d = 0;
    if (player == 1) begin
      if (a == 'h77) d = 1;
      if (a == 'h73) d = 2;
      if (a == 'h61) d = 3;
      if (a == 'h64) d = 4;
    end else begin
      if (a == 'h69) d = 1;
      if (a == 'h6B) d = 2;
      if (a == 'h6A) d = 3;
      if (a == 'h6C) d = 4;
    end
    return d;
  endfunction

  task automatic model_reset();
    m_state = 0; m_p1d = 0; m_p2d = 0;
    m_f1 = 0; m_f2 = 0; m_start = 0;
    m_prev_p = 0; m_prev_a = 0;
    last1 = -1000; last2 = -1000;
  endtask

  task automatic model_cycle(input int p, input int a);
    bit mk, rl;
    mk = (p == 1) && (a != 0) && ((p != m_prev_p) || (a != m_prev_a));
    rl = (p == 0) && (m_prev_p == 1);
    m_f1 = 0; m_f2 = 0; m_start = 0;
    if (mk) begin
      if (m_state == 0) begin
        if (a == 'h0D) begin m_state = 1; m_start = 1; end
      end else if (a == 'h08) begin
        m_state = 0; m_p1d = 0; m_p2d = 0;
        last1 = -1000; last2 = -1000;
      end else if (a == 'h70) begin
        m_state = (m_state == 1) ? 2 : 1;
        m_p1d = 0; m_p2d = 0;
      end else if (m_state == 1) begin
        if (dir_of(a, 1) != 0) m_p1d = dir_of(a, 1);
        if (dir_of(a, 2) != 0) m_p2d = dir_of(a, 2);
        if (a == 'h20 && cyc - last1 > FC) begin m_f1 = 1; last1 = cyc; end
        if (a == 'h30 && cyc - last2 > FC) begin m_f2 = 1; last2 = cyc; end
      end
    end else if (rl) begin
      m_p1d = 0; m_p2d = 0;
    end
    m_prev_p = p; m_prev_a = a;
    cyc++;
  endtask

  task automatic step(input logic p, input logic [7:0] a, input string w);
    press = p;
    ascii = a;
    model_cycle(int'(p), int'(a));
    @(posedge clk_100mhz);
    #1;
    if (p1_fire === 1'b1) p1_pulses++;
    if (p2_fire === 1'b1) p2_pulses++;
    check_all(w);
  endtask

  task automatic zeros(input string w);
    chk({w, ".p1_dir"}, 32'(p1_dir), 0);
    chk({w, ".p2_dir"}, 32'(p2_dir), 0);
    chk({w, ".p1_fire"}, 32'(p1_fire), 0);
    chk({w, ".p2_fire"}, 32'(p2_fire), 0);
    chk({w, ".state"}, 32'(game_state), 0);
    chk({w, ".start"}, 32'(start), 0);
  endtask

  task automatic do_reset(input bit clear_inputs, input string w);
    #2;
    rst_n = 1'b0;
    if (clear_inputs) begin press = 1'b0; ascii = 8'h00; end
    #1;
    zeros({w, ".async"});
    model_reset();
    @(posedge clk_100mhz);
    @(posedge clk_100mhz);
    #1;
    zeros({w, ".held"});
    #2;
    rst_n = 1'b1;
  endtask

  logic [7:0] keys [15] = '{8'h00, 8'h0D, 8'h70, 8'h08, 8'h77, 8'h73,
                            8'h61, 8'h64, 8'h20, 8'h69, 8'h6B, 8'h6A,
                            8'h6C, 8'h30, 8'h41};

  initial begin
    cyc = 0; p1_pulses = 0; p2_pulses = 0;
    model_reset();
    #3;
    zeros("por");
    #4;
    rst_n = 1'b1;
    @(posedge clk_100mhz);
    #1;

    step(0, 8'h00, "idle0");
    step(1, 8'h77, "idle_w");
    step(1, 8'h20, "idle_fire");
    step(1, 8'h00, "idle_nul");
    step(0, 8'h00, "idle_rel");
    step(1, 8'h0D, "enter");
    chk("enter.start_hi", 32'(start), 1);
    chk("enter.run", 32'(game_state), 1);
    step(1, 8'h0D, "enter_hold");
    chk("enter.start_lo", 32'(start), 0);
    step(0, 8'h00, "enter_rel");

    step(1, 8'h77, "w");
    chk("w.p1", 32'(p1_dir), 1);
    step(1, 8'h64, "d");
    chk("d.p1", 32'(p1_dir), 4);
    step(1, 8'h69, "i");
    chk("i.p2", 32'(p2_dir), 1);
    chk("i.p1", 32'(p1_dir), 4);
    step(1, 8'h00, "nul_ignored");
    chk("nul.p1", 32'(p1_dir), 4);
    step(0, 8'h00, "rel");
    chk("rel.p1", 32'(p1_dir), 0);
    chk("rel.p2", 32'(p2_dir), 0);

    p1_pulses = 0; p2_pulses = 0;
    step(1, 8'h20, "fire1");
    chk("fire1.pulse", 32'(p1_fire), 1);
    step(0, 8'h00, "fire1_rel");
    step(1, 8'h30, "fire_p2");
    chk("fire_p2.pulse", 32'(p2_fire), 1);
    step(0, 8'h00, "fire_p2_rel");
    step(0, 8'h00, "gap");
    step(1, 8'h20, "fire_early");
    chk("fire_early.drop", 32'(p1_fire), 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, "cool");
    step(1, 8'h20, "fire2");
    chk("fire2.pulse", 32'(p1_fire), 1);
    chk("fire.count", 32'(p1_pulses), 2);
    chk("fire.p2count", 32'(p2_pulses), 1);
    step(0, 8'h00, "fire2_rel");

    step(1, 8'h70, "pause");
    chk("pause.state", 32'(game_state), 2);
    step(1, 8'h77, "pause_w");
    step(1, 8'h20, "pause_fire");
    step(1, 8'h70, "resume");
    chk("resume.state", 32'(game_state), 1);
    chk("resume.start", 32'(start), 0);
    chk("resume.p1", 32'(p1_dir), 0);

    step(1, 8'h61, "a");
    chk("a.p1", 32'(p1_dir), 3);
    step(1, 8'h08, "bksp");
    chk("bksp.state", 32'(game_state), 0);
    chk("bksp.p1", 32'(p1_dir), 0);
    step(1, 8'h20, "idle_space");
    chk("idle_space.fire", 32'(p1_fire), 0);

    step(1, 8'h0D, "enter2");
    step(1, 8'h77, "w2");
    p1_pulses = 0;
    for (int i = 0; i < 50; i++) step(1, 8'h20, "hold");
    do_reset(1'b0, "midhold");
    for (int i = 0; i < 50; i++) step(1, 8'h20, "hold2");
    chk("hold.count", 32'(p1_pulses), 1);

    step(0, 8'h00, "rnd_init");
    for (int i = 0; i < 3000; i++) begin
      logic       p;
      logic [7:0] a;
      p = press;
      a = ascii;
      if ($urandom_range(1, 0) == 1) begin
        p = ($urandom_range(3, 0) != 0);
        a = keys[$urandom_range(14, 0)];
      end
      step(p, a, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
